operand_fwd_unit: RTL and testbench
===================================

// Module: operand_fwd_unit
// PURPOSE
// Pipelined successor of the core's operand/write-back glue. It selects ALU operands with EX->MEM and WB->EX forwarding.
// It carries results through internal MEM and WB registers, waits for load data, and drives the register-file write port.
// It raises stall_o on load-use hazards and while a load is outstanding, and retires a load with error after a timeout.
// PARAMETERS
// DATA_WIDTH      32  datapath width
// ADDR_WIDTH      32  PC / immediate width (== DATA_WIDTH)
// REG_ADDR_WIDTH  5   register index width
// LOAD_TIMEOUT    16  max cycles waiting for mem_rvalid_i in M_LOAD (>=1)
// PORTS
// clk_i                 in   1               clock, all state on rising edge
// rst_i                 in   1               synchronous reset, active-high
// ex_valid_i            in   1               instruction present in EX
// ex_rs1_addr_i/rs2     in   REG_ADDR_WIDTH  EX source registers
// rs1_valid_i/rs2_valid_i/imm_valid_i in 1   operand validity from decoder
// imm_i, pc_i, pc_plus4_i in ADDR_WIDTH      immediate, PC, PC+4 of EX instr
// alu_op_a_mux_sel_i/b  in   2               toothless_pkg ALU_OP_A/B_SEL_*
// rf_rp_a_i/rf_rp_b_i   in   DATA_WIDTH      register-file read data
// alu_op_a_o/alu_op_b_o out  DATA_WIDTH      ALU operands (combinational)
// alu_result_i          in   DATA_WIDTH      ALU result of EX instr
// ex_rd_addr_i          in   REG_ADDR_WIDTH  EX destination
// ex_rd_we_i            in   1               EX instr writes rd
// rf_wp_mux_sel_i       in   2               RF_WP_A_SEL_ALU/PCPLUS4/LSU of EX instr
// mem_rvalid_i          in   1               load data valid
// mem_rdata_i           in   DATA_WIDTH      load data
// rf_we_o/rf_waddr_o/rf_wp_o out 1/REG_ADDR_WIDTH/DATA_WIDTH  registered RF write port
// stall_o               out  1               hold EX (combinational)
// load_err_o            out  1               one-cycle pulse on load timeout
// BEHAVIOUR
// - Reset: MEM/WB valid=0, FSM=M_IDLE, timeout counter=0, rf_we_o=0, rf_waddr_o=0, rf_wp_o=0, load_err_o=0.
//   Any in-flight load is dropped; mem_rvalid_i is ignored in M_IDLE.
// - Operand A: REG -> fwd(rs1) if rs1_valid_i else 0; PC -> pc_i; IMM -> imm_i if imm_valid_i else 0; other -> 0.
//   Operand B: REG -> fwd(rs2) if rs2_valid_i else 0; IMM -> imm_i if imm_valid_i else 0; other -> 0.
// - fwd(rs) priority: (1) MEM valid, we, non-load, rd==rs, rd!=0 -> MEM data (alu_result or pc_plus4 captured).
//   (2) WB valid (rf_we_o), rf_waddr_o==rs -> rf_wp_o. (3) rf_rp_*_i.
// - MEM FSM: M_IDLE (empty), M_FULL (ALU/PC+4 result ready), M_LOAD (awaiting data).
//   mem_adv = M_IDLE | M_FULL | (M_LOAD & mem_rvalid_i) | (M_LOAD & cnt==LOAD_TIMEOUT-1).
//   hazard = M_LOAD & mem_rd!=0 & ((REG sel & rsN_valid & rsN==mem_rd) for A or B).
//   stall_o = ex_valid_i & (!mem_adv | hazard).
// - Capture: ex_valid_i & !stall_o -> MEM loads EX fields; next state M_LOAD if sel==LSU, else M_FULL.
//   Capture while mem_adv & no EX capture -> M_IDLE. While !mem_adv, MEM holds and cnt increments; cnt clears on entry to M_LOAD.
// - WB: on mem_adv with MEM valid, WB <= {we & rd!=0, rd, data}. data = mem_rdata_i for a load with rvalid, 0 on timeout, else captured result.
//   Otherwise rf_we_o <= 0 (bubble). rf_we_o is high for exactly one cycle per retired write.
// - Latency: non-load EX at edge N -> rf_we_o high in cycle after edge N+1.
//   A load retires the cycle after mem_rvalid_i; load-use costs >=1 stall cycle, then WB-forward.
// - Timeout: load_err_o=1 for one cycle alongside the retiring rf_we_o; rd written with 0.
// - Simultaneous rvalid and timeout: rvalid wins, no error.
// - rd==0 is never forwarded and never written.
// TESTING
// 1 ALU->ALU: I1 x1<=5, I2 (next cycle) reads x1 REG -> alu_op_a_o=5 from MEM, stall_o=0, rf_we_o x1=5 two edges after I1.
// 2 WB forward: I1 x2<=7, bubble, I3 reads rs2=x2, rf_rp_b_i=0 -> alu_op_b_o=7.
// 3 Load-use: load x3, dependent next; rvalid 2 cycles later with 0xDEADBEEF.
//   -> stall_o high 3 cycles, then alu_op_a_o=0xDEADBEEF via WB, rf_we_o x3.
// 4 Timeout (LOAD_TIMEOUT=4): load, no rvalid -> stall 4 cycles, load_err_o single pulse, rf_wp_o=0 to rd, pipeline resumes.
// 5 x0: write x0=9 then read x0 with rf_rp_a_i=0 -> alu_op_a_o=0, rf_we_o never 1. Also PC/IMM/invalid selects -> pc_i/imm_i/0.
// 6 Reset in M_LOAD: assert rst_i 1 cycle, late rvalid -> stall_o=0, rf_we_o=0, load_err_o=0 afterwards.

Source files
------------

// File: rtl/operand_fwd_unit.sv
// Operand selection with EX->MEM / WB->EX forwarding, MEM/WB pipeline registers,
// load-wait FSM with timeout, and the registered register-file write port.
module operand_fwd_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LOAD_TIMEOUT   = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      ex_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rs2_addr_i,
  input  logic                      rs1_valid_i,
  input  logic                      rs2_valid_i,
  input  logic                      imm_valid_i,
  input  logic [ADDR_WIDTH-1:0]     imm_i,
  input  logic [ADDR_WIDTH-1:0]     pc_i,
  input  logic [ADDR_WIDTH-1:0]     pc_plus4_i,
  input  logic [1:0]                alu_op_a_mux_sel_i,
  input  logic [1:0]                alu_op_b_mux_sel_i,
  input  logic [DATA_WIDTH-1:0]     rf_rp_a_i,
  input  logic [DATA_WIDTH-1:0]     rf_rp_b_i,
  output logic [DATA_WIDTH-1:0]     alu_op_a_o,
  output logic [DATA_WIDTH-1:0]     alu_op_b_o,
  input  logic [DATA_WIDTH-1:0]     alu_result_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_i,
  input  logic                      ex_rd_we_i,
  input  logic [1:0]                rf_wp_mux_sel_i,
  input  logic                      mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
  output logic                      rf_we_o,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0]     rf_wp_o,
  output logic                      stall_o,
  output logic                      load_err_o
);

  localparam logic [1:0] ALU_OP_A_SEL_REG = 2'd0;
  localparam logic [1:0] ALU_OP_A_SEL_PC  = 2'd1;
  localparam logic [1:0] ALU_OP_A_SEL_IMM = 2'd2;
  localparam logic [1:0] ALU_OP_B_SEL_REG = 2'd0;
  localparam logic [1:0] ALU_OP_B_SEL_IMM = 2'd1;
  localparam logic [1:0] RF_WP_A_SEL_ALU     = 2'd0;
  localparam logic [1:0] RF_WP_A_SEL_PCPLUS4 = 2'd1;
  localparam logic [1:0] RF_WP_A_SEL_LSU     = 2'd2;

  localparam int CNT_WIDTH = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(LOAD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    M_IDLE,
    M_FULL,
    M_LOAD
  } mem_state_e;

  mem_state_e                mem_state, mem_state_n;
  logic [CNT_WIDTH-1:0]      cnt;
  logic [REG_ADDR_WIDTH-1:0] mem_rd;
  logic                      mem_we;
  logic [DATA_WIDTH-1:0]     mem_data;

  logic                      mem_fwd_ok;
  logic [DATA_WIDTH-1:0]     fwd_a, fwd_b;
  logic                      cnt_expired, mem_adv, timeout, hazard, capture;
  logic                      use_rs1, use_rs2;

  // Forwarding sources: a completed non-load in MEM beats the value being written back.
  always_comb begin
    mem_fwd_ok = (mem_state == M_FULL) && mem_we && (mem_rd != '0);
    fwd_a = rf_rp_a_i;
    fwd_b = rf_rp_b_i;
    if (mem_fwd_ok && (mem_rd == ex_rs1_addr_i)) begin
      fwd_a = mem_data;
    end else if (rf_we_o && (rf_waddr_o == ex_rs1_addr_i)) begin
      fwd_a = rf_wp_o;
    end
    if (mem_fwd_ok && (mem_rd == ex_rs2_addr_i)) begin
      fwd_b = mem_data;
    end else if (rf_we_o && (rf_waddr_o == ex_rs2_addr_i)) begin
      fwd_b = rf_wp_o;
    end
  end

  always_comb begin
    alu_op_a_o = '0;
    case (alu_op_a_mux_sel_i)
      ALU_OP_A_SEL_REG: alu_op_a_o = rs1_valid_i ? fwd_a : '0;
      ALU_OP_A_SEL_PC:  alu_op_a_o = pc_i;
      ALU_OP_A_SEL_IMM: alu_op_a_o = imm_valid_i ? imm_i : '0;
      default:          alu_op_a_o = '0;
    endcase
  end

  always_comb begin
    alu_op_b_o = '0;
    case (alu_op_b_mux_sel_i)
      ALU_OP_B_SEL_REG: alu_op_b_o = rs2_valid_i ? fwd_b : '0;
      ALU_OP_B_SEL_IMM: alu_op_b_o = imm_valid_i ? imm_i : '0;
      default:          alu_op_b_o = '0;
    endcase
  end

  // MEM advances unless a load is still waiting; rvalid takes priority over timeout.
  always_comb begin
    use_rs1     = (alu_op_a_mux_sel_i == ALU_OP_A_SEL_REG) && rs1_valid_i && (ex_rs1_addr_i == mem_rd);
    use_rs2     = (alu_op_b_mux_sel_i == ALU_OP_B_SEL_REG) && rs2_valid_i && (ex_rs2_addr_i == mem_rd);
    cnt_expired = (cnt == CNT_LAST);
    mem_adv     = (mem_state != M_LOAD) || mem_rvalid_i || cnt_expired;
    timeout     = (mem_state == M_LOAD) && !mem_rvalid_i && cnt_expired;
    hazard      = (mem_state == M_LOAD) && (mem_rd != '0) && (use_rs1 || use_rs2);
    stall_o     = ex_valid_i && (!mem_adv || hazard);
    capture     = ex_valid_i && !stall_o;
  end

  always_comb begin
    mem_state_n = mem_state;
    if (capture) begin
      mem_state_n = (rf_wp_mux_sel_i == RF_WP_A_SEL_LSU) ? M_LOAD : M_FULL;
    end else if (mem_adv) begin
      mem_state_n = M_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_state <= M_IDLE;
      cnt       <= '0;
      mem_rd    <= '0;
      mem_we    <= 1'b0;
      mem_data  <= '0;
    end else begin
      mem_state <= mem_state_n;
      if (capture) begin
        cnt      <= '0;
        mem_rd   <= ex_rd_addr_i;
        mem_we   <= ex_rd_we_i;
        mem_data <= (rf_wp_mux_sel_i == RF_WP_A_SEL_PCPLUS4) ? pc_plus4_i : alu_result_i;
      end else if (!mem_adv) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

  // Write-back register: retires whatever leaves MEM, otherwise inserts a bubble.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wp_o    <= '0;
      load_err_o <= 1'b0;
    end else if (mem_adv && (mem_state != M_IDLE)) begin
      rf_we_o    <= mem_we && (mem_rd != '0);
      rf_waddr_o <= mem_rd;
      load_err_o <= timeout;
      if (mem_state == M_LOAD) begin
        rf_wp_o <= mem_rvalid_i ? mem_rdata_i : '0;
      end else begin
        rf_wp_o <= mem_data;
      end
    end else begin
      rf_we_o    <= 1'b0;
      load_err_o <= 1'b0;
    end
  end

  logic unused_sel;
  assign unused_sel = (RF_WP_A_SEL_ALU == 2'd0);

endmodule

// File: tb/tb_operand_fwd_unit.sv
// Directed bench for operand_fwd_unit: combinational operand/stall checks per cycle,
// plus a scoreboard queue of expected register-file writes checked by a monitor.
module tb_operand_fwd_unit;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int LT = 4;

  localparam logic [1:0] A_REG = 2'd0, A_PC = 2'd1, A_IMM = 2'd2, A_NONE = 2'd3;
  localparam logic [1:0] B_REG = 2'd0, B_IMM = 2'd1, B_NONE = 2'd3;
  localparam logic [1:0] WP_ALU = 2'd0, WP_PC4 = 2'd1, WP_LSU = 2'd2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          ex_valid_i;
  logic [RW-1:0] ex_rs1_addr_i, ex_rs2_addr_i, ex_rd_addr_i;
  logic          rs1_valid_i, rs2_valid_i, imm_valid_i, ex_rd_we_i, mem_rvalid_i;
  logic [DW-1:0] imm_i, pc_i, pc_plus4_i, rf_rp_a_i, rf_rp_b_i, alu_result_i, mem_rdata_i;
  logic [1:0]    alu_op_a_mux_sel_i, alu_op_b_mux_sel_i, rf_wp_mux_sel_i;
  logic [DW-1:0] alu_op_a_o, alu_op_b_o, rf_wp_o;
  logic [RW-1:0] rf_waddr_o;
  logic          rf_we_o, stall_o, load_err_o;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic          valid;
    logic [RW-1:0] rs1, rs2, rd;
    logic          rs1v, rs2v, immv, we, rvalid;
    logic [1:0]    asel, bsel, wpsel;
    logic [DW-1:0] imm, pc, pc4, rpa, rpb, alu, rdata;
  } ex_t;

  typedef struct {
    logic [RW-1:0] addr;
    logic [DW-1:0] data;
    logic          err;
  } wb_t;

  wb_t exp_q[$];
  wb_t mon_exp;
  ex_t s;

  operand_fwd_unit #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(DW), .REG_ADDR_WIDTH(RW), .LOAD_TIMEOUT(LT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .ex_valid_i(ex_valid_i),
    .ex_rs1_addr_i(ex_rs1_addr_i), .ex_rs2_addr_i(ex_rs2_addr_i),
    .rs1_valid_i(rs1_valid_i), .rs2_valid_i(rs2_valid_i), .imm_valid_i(imm_valid_i),
    .imm_i(imm_i), .pc_i(pc_i), .pc_plus4_i(pc_plus4_i),
    .alu_op_a_mux_sel_i(alu_op_a_mux_sel_i), .alu_op_b_mux_sel_i(alu_op_b_mux_sel_i),
    .rf_rp_a_i(rf_rp_a_i), .rf_rp_b_i(rf_rp_b_i),
    .alu_op_a_o(alu_op_a_o), .alu_op_b_o(alu_op_b_o),
    .alu_result_i(alu_result_i), .ex_rd_addr_i(ex_rd_addr_i), .ex_rd_we_i(ex_rd_we_i),
    .rf_wp_mux_sel_i(rf_wp_mux_sel_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wp_o(rf_wp_o),
    .stall_o(stall_o), .load_err_o(load_err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic ex_t nop();
    ex_t n;
    n.valid = 1'b0; n.rs1 = '0; n.rs2 = '0; n.rd = '0;
    n.rs1v = 1'b0; n.rs2v = 1'b0; n.immv = 1'b0; n.we = 1'b0; n.rvalid = 1'b0;
    n.asel = A_NONE; n.bsel = B_NONE; n.wpsel = WP_ALU;
    n.imm = '0; n.pc = '0; n.pc4 = '0; n.rpa = '0; n.rpb = '0; n.alu = '0; n.rdata = '0;
    return n;
  endfunction

  function automatic ex_t wr(input logic [RW-1:0] rd, input logic [1:0] wpsel, input logic [DW-1:0] alu);
    ex_t n = nop();
    n.valid = 1'b1; n.rd = rd; n.we = 1'b1; n.wpsel = wpsel; n.alu = alu;
    return n;
  endfunction

  function automatic ex_t rdA(input logic [RW-1:0] rs1, input logic [DW-1:0] rpa);
    ex_t n = nop();
    n.valid = 1'b1; n.rs1 = rs1; n.rs1v = 1'b1; n.asel = A_REG; n.rpa = rpa;
    return n;
  endfunction

  task automatic driveInputs(input ex_t v);
    ex_valid_i = v.valid; ex_rs1_addr_i = v.rs1; ex_rs2_addr_i = v.rs2; ex_rd_addr_i = v.rd;
    rs1_valid_i = v.rs1v; rs2_valid_i = v.rs2v; imm_valid_i = v.immv; ex_rd_we_i = v.we;
    mem_rvalid_i = v.rvalid; alu_op_a_mux_sel_i = v.asel; alu_op_b_mux_sel_i = v.bsel;
    rf_wp_mux_sel_i = v.wpsel; imm_i = v.imm; pc_i = v.pc; pc_plus4_i = v.pc4;
    rf_rp_a_i = v.rpa; rf_rp_b_i = v.rpb; alu_result_i = v.alu; mem_rdata_i = v.rdata;
  endtask

  task automatic applyStimulus(input ex_t v);
    @(negedge clk_i);
    driveInputs(v);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic expectWrite(input logic [RW-1:0] a, input logic [DW-1:0] d, input logic e);
    wb_t w;
    w.addr = a; w.data = d; w.err = e;
    exp_q.push_back(w);
  endtask

  // Monitor: every retiring write or error pulse must match the oldest expected write.
  always @(negedge clk_i) begin
    if (rf_we_o || load_err_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("[TB] FAIL wb_unexpected: got we=%0b addr=%0d data=0x%0h err=%0b, expected no write",
                 rf_we_o, rf_waddr_o, rf_wp_o, load_err_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rf_we_o && rf_waddr_o == mon_exp.addr && rf_wp_o == mon_exp.data && load_err_o == mon_exp.err)
          passes++;
        else
          $display("[TB] FAIL wb_write: got we=%0b addr=%0d data=0x%0h err=%0b, expected addr=%0d data=0x%0h err=%0b",
                   rf_we_o, rf_waddr_o, rf_wp_o, load_err_o, mon_exp.addr, mon_exp.data, mon_exp.err);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    driveInputs(nop());
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    driveInputs(rdA(5'd1, 32'hCAFE));
    #1;
    checkOutput("rst_rf_we", rf_we_o, 0);
    checkOutput("rst_waddr", rf_waddr_o, 0);
    checkOutput("rst_wp", rf_wp_o, 0);
    checkOutput("rst_err", load_err_o, 0);
    checkOutput("rst_stall", stall_o, 0);
    checkOutput("rst_opa_no_fwd", alu_op_a_o, 32'hCAFE);

    // ALU -> ALU forwarding from MEM
    applyStimulus(wr(5'd1, WP_ALU, 32'd5)); expectWrite(5'd1, 32'd5, 1'b0);
    checkOutput("t1_issue_stall", stall_o, 0);
    applyStimulus(rdA(5'd1, 32'h111));
    checkOutput("t1_mem_fwd", alu_op_a_o, 32'd5);
    checkOutput("t1_stall", stall_o, 0);
    applyStimulus(nop());
    checkOutput("t1_we_latency", rf_we_o, 1);
    checkOutput("t1_waddr", rf_waddr_o, 1);
    applyStimulus(nop());
    checkOutput("t1_we_pulse", rf_we_o, 0);

    // WB forwarding after a bubble
    applyStimulus(wr(5'd2, WP_ALU, 32'd7)); expectWrite(5'd2, 32'd7, 1'b0);
    applyStimulus(nop());
    s = nop(); s.valid = 1'b1; s.rs2 = 5'd2; s.rs2v = 1'b1; s.bsel = B_REG; s.rpb = 32'd0;
    applyStimulus(s);
    checkOutput("t2_wb_fwd", alu_op_b_o, 32'd7);
    checkOutput("t2_opa_other", alu_op_a_o, 0);
    applyStimulus(nop());

    // Load-use: three stall cycles, then WB forward
    applyStimulus(wr(5'd3, WP_LSU, 32'h0)); expectWrite(5'd3, 32'hDEADBEEF, 1'b0);
    checkOutput("t3_issue_stall", stall_o, 0);
    applyStimulus(rdA(5'd3, 32'h0));
    checkOutput("t3_stall_c1", stall_o, 1);
    applyStimulus(rdA(5'd3, 32'h0));
    checkOutput("t3_stall_c2", stall_o, 1);
    s = rdA(5'd3, 32'h0); s.rvalid = 1'b1; s.rdata = 32'hDEADBEEF;
    applyStimulus(s);
    checkOutput("t3_stall_c3", stall_o, 1);
    applyStimulus(rdA(5'd3, 32'h0));
    checkOutput("t3_released", stall_o, 0);
    checkOutput("t3_wb_fwd", alu_op_a_o, 32'hDEADBEEF);
    checkOutput("t3_we", rf_we_o, 1);
    applyStimulus(nop());

    // Load timeout
    applyStimulus(wr(5'd4, WP_LSU, 32'h0)); expectWrite(5'd4, 32'h0, 1'b1);
    for (int i = 0; i < LT; i++) begin
      applyStimulus(rdA(5'd4, 32'h55));
      checkOutput($sformatf("t4_stall_c%0d", i), stall_o, 1);
      checkOutput($sformatf("t4_no_err_c%0d", i), load_err_o, 0);
    end
    applyStimulus(rdA(5'd4, 32'h55));
    checkOutput("t4_resume", stall_o, 0);
    checkOutput("t4_err_pulse", load_err_o, 1);
    checkOutput("t4_fwd_zero", alu_op_a_o, 0);
    applyStimulus(nop());
    checkOutput("t4_err_single", load_err_o, 0);

    // x0 is never forwarded nor written; PC/IMM/invalid selects
    applyStimulus(wr(5'd0, WP_ALU, 32'd9));
    applyStimulus(rdA(5'd0, 32'h0));
    checkOutput("t5_x0_mem", alu_op_a_o, 0);
    applyStimulus(rdA(5'd0, 32'h0));
    checkOutput("t5_x0_wb", alu_op_a_o, 0);
    checkOutput("t5_x0_no_we", rf_we_o, 0);
    s = nop(); s.valid = 1'b1; s.asel = A_PC; s.pc = 32'h1000; s.bsel = B_IMM; s.immv = 1'b1; s.imm = 32'h24;
    applyStimulus(s);
    checkOutput("t5_pc", alu_op_a_o, 32'h1000);
    checkOutput("t5_imm_b", alu_op_b_o, 32'h24);
    s = nop(); s.valid = 1'b1; s.asel = A_IMM; s.immv = 1'b1; s.imm = 32'h77;
    applyStimulus(s);
    checkOutput("t5_imm_a", alu_op_a_o, 32'h77);
    s = nop(); s.valid = 1'b1; s.asel = A_IMM; s.imm = 32'h77; s.bsel = B_REG; s.rpb = 32'hABC;
    applyStimulus(s);
    checkOutput("t5_imm_invalid", alu_op_a_o, 0);
    checkOutput("t5_rs2_invalid", alu_op_b_o, 0);
    s = nop(); s.valid = 1'b1; s.asel = A_REG; s.rpa = 32'hABC; s.bsel = B_IMM; s.imm = 32'h5;
    applyStimulus(s);
    checkOutput("t5_rs1_invalid", alu_op_a_o, 0);
    checkOutput("t5_imm_b_invalid", alu_op_b_o, 0);
    s = wr(5'd5, WP_PC4, 32'h999); s.pc4 = 32'h2004;
    applyStimulus(s); expectWrite(5'd5, 32'h2004, 1'b0);
    applyStimulus(rdA(5'd5, 32'h0));
    checkOutput("t5_pc4_fwd", alu_op_a_o, 32'h2004);
    applyStimulus(nop());

    // Reset while a load is outstanding
    applyStimulus(wr(5'd6, WP_LSU, 32'h0));
    applyStimulus(nop());
    rst_i = 1'b1;
    applyStimulus(nop());
    rst_i = 1'b0;
    checkOutput("t6_stall_after_rst", stall_o, 0);
    s = nop(); s.rvalid = 1'b1; s.rdata = 32'h1234;
    applyStimulus(s);
    applyStimulus(rdA(5'd6, 32'h66));
    checkOutput("t6_no_stall", stall_o, 0);
    checkOutput("t6_no_fwd", alu_op_a_o, 32'h66);
    checkOutput("t6_no_we", rf_we_o, 0);
    checkOutput("t6_no_err", load_err_o, 0);
    applyStimulus(nop());
    checkOutput("t6_no_we_late", rf_we_o, 0);

    // rvalid in the timeout cycle wins; independent EX still stalls while waiting
    applyStimulus(wr(5'd7, WP_LSU, 32'h0)); expectWrite(5'd7, 32'hBEEF, 1'b0);
    for (int i = 0; i < LT - 1; i++) begin
      applyStimulus(rdA(5'd9, 32'h99));
      checkOutput($sformatf("t7_wait_stall_c%0d", i), stall_o, 1);
    end
    s = rdA(5'd9, 32'h99); s.rvalid = 1'b1; s.rdata = 32'hBEEF;
    applyStimulus(s);
    checkOutput("t7_adv_stall", stall_o, 0);
    applyStimulus(nop());
    checkOutput("t7_no_err", load_err_o, 0);
    applyStimulus(nop());
    applyStimulus(nop());

    checkOutput("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
